ahb_burst_sequencer: RTL and testbench

- Manager-side AHB address/control phase generator.
- Accepts one burst command per handshake and drives HADDR/HTRANS/HBURST/HSIZE/HWRITE/HPROT for every beat of the burst. Supports all eight HBURST types, a parametrised bus width, BUSY insertion, 1KB boundary splitting and the two-cycle ERROR response.
- Sits between the master driver BFM and the AHB interface; the write data path stays outside this block.

---
 rtl/ahb_burst_sequencer_pkg.sv | 114 +++++++++++
 rtl/ahb_burst_addr_gen.sv | 33 +++
 rtl/ahb_burst_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_ahb_burst_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_burst_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// ahb_burst_sequencer_pkg
// Shared AHB encodings, sequencer state type, burst command bundle and the
// address arithmetic helpers. These are used by the manager-side sequencer
// and by anything else that must predict the beat addresses of a burst.
// Address helpers work on a 64-bit value; callers truncate to their own
// address width, which gives the modulo-2^ADDR_WIDTH behaviour.
// ----------------------------------------------------------------------------
package ahb_burst_sequencer_pkg;

    localparam int KB_BOUNDARY     = 1024;
    localparam int ADDR_CALC_WIDTH = 64;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } ahb_transfer_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } ahb_burst_e;

    typedef enum logic [2:0] {
        SIZE_BYTE     = 3'd0,
        SIZE_HALFWORD = 3'd1,
        SIZE_WORD     = 3'd2,
        SIZE_DWORD    = 3'd3,
        SIZE_128      = 3'd4,
        SIZE_256      = 3'd5,
        SIZE_512      = 3'd6,
        SIZE_1024     = 3'd7
    } ahb_hsize_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } ahb_resp_e;

    // HPROT bits: [0] data/opcode, [1] privileged, [2] bufferable, [3] cacheable
    typedef logic [3:0] ahb_prot_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_NSEQ = 3'd1,
        ST_SEQ  = 3'd2,
        ST_BUSY = 3'd3,
        ST_LAST = 3'd4,
        ST_ERR  = 3'd5
    } ahb_seq_state_e;

    // Control part of a burst command. Address and length are parameter
    // sized, so they are kept in separately sized registers by the user.
    typedef struct packed {
        ahb_burst_e burst;
        ahb_hsize_e size;
        logic       write;
        ahb_prot_t  prot;
    } ahb_burst_cmd_s;

    function automatic bit is_wrap(input ahb_burst_e burst);
        return burst inside {BURST_WRAP4, BURST_WRAP8, BURST_WRAP16};
    endfunction

    function automatic bit is_fixed_incr(input ahb_burst_e burst);
        return burst inside {BURST_INCR4, BURST_INCR8, BURST_INCR16};
    endfunction

    function automatic bit is_incr(input ahb_burst_e burst);
        return !is_wrap(burst);
    endfunction

    // Beat total of a burst; len only matters for undefined-length INCR,
    // where zero counts as a single beat.
    function automatic int burst_beats(input ahb_burst_e burst, input int len);
        case (burst)
            BURST_SINGLE:              return 1;
            BURST_WRAP4,  BURST_INCR4: return 4;
            BURST_WRAP8,  BURST_INCR8: return 8;
            BURST_WRAP16, BURST_INCR16: return 16;
            default:                   return (len < 1) ? 1 : len;
        endcase
    endfunction

    // Bytes covered by a fixed-length burst (the wrap window for WRAPx).
    function automatic logic [ADDR_CALC_WIDTH-1:0] burst_span(input ahb_burst_e burst,
                                                              input ahb_hsize_e size);
        return ADDR_CALC_WIDTH'(burst_beats(burst, 1)) << size;
    endfunction

    function automatic logic [ADDR_CALC_WIDTH-1:0] next_addr(input logic [ADDR_CALC_WIDTH-1:0] addr,
                                                             input ahb_burst_e burst,
                                                             input ahb_hsize_e size);
        logic [ADDR_CALC_WIDTH-1:0] inc;
        logic [ADDR_CALC_WIDTH-1:0] sum;
        logic [ADDR_CALC_WIDTH-1:0] mask;
        inc  = ADDR_CALC_WIDTH'(1) << size;
        sum  = addr + inc;
        mask = burst_span(burst, size) - ADDR_CALC_WIDTH'(1);
        if (is_wrap(burst)) begin
            return (addr & ~mask) | (sum & mask);
        end
        return sum;
    endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// ahb_burst_addr_gen
// Purely combinational beat address generator.
//   addr_i       current beat address
//   burst_i      HBURST encoding
//   size_i       HSIZE encoding
//   next_addr_o  address of the following beat (wraps inside the window for
//                WRAPx, modulo 2^ADDR_WIDTH otherwise)
//   wrap_span_o  bytes covered by a fixed-length burst of this type/size
//   kb_cross_o   incrementing burst whose next beat starts a new 1KB page
// ----------------------------------------------------------------------------
module ahb_burst_addr_gen
    import ahb_burst_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            burst_i,
    input  logic [2:0]            size_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic [ADDR_WIDTH-1:0] wrap_span_o,
    output logic                  kb_cross_o
);

    always_comb begin
        next_addr_o = ADDR_WIDTH'(next_addr(ADDR_CALC_WIDTH'(addr_i),
                                            ahb_burst_e'(burst_i),
                                            ahb_hsize_e'(size_i)));
        wrap_span_o = ADDR_WIDTH'(burst_span(ahb_burst_e'(burst_i), ahb_hsize_e'(size_i)));
        kb_cross_o  = is_incr(ahb_burst_e'(burst_i)) && (next_addr_o[9:0] == 10'd0);
    end

endmodule

// File: rtl/ahb_burst_sequencer.sv
// ----------------------------------------------------------------------------
// ahb_burst_sequencer
// Manager-side AHB address/control phase generator. One burst command is
// accepted per cmdValid/cmdReady handshake; every beat's address phase is
// then driven on HADDR/HTRANS/HBURST/HSIZE/HWRITE/HPROT.
//   HCLK, HRESET      clock, synchronous active-high reset
//   cmd*              burst command (address, burst, size, write, prot, len)
//   cmdValid/Ready    command handshake; cmdReady is high only when idle
//   beatStall         request a BUSY cycle before the next SEQ beat
//   HREADY, HRESP     bus ready and response
//   H*                address/control phase outputs
//   beatCount         address phases accepted in the current burst
//   done, err         one-cycle end-of-burst pulse, err = ERROR or illegal
// ----------------------------------------------------------------------------
module ahb_burst_sequencer
    import ahb_burst_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_INCR_LEN = 256,
    parameter int LEN_WIDTH    = $clog2(MAX_INCR_LEN + 1)
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic [ADDR_WIDTH-1:0] cmdAddr,
    input  logic [2:0]            cmdBurst,
    input  logic [2:0]            cmdSize,
    input  logic                  cmdWrite,
    input  logic [3:0]            cmdProt,
    input  logic [LEN_WIDTH-1:0]  cmdLen,
    input  logic                  beatStall,
    input  logic                  HREADY,
    input  logic                  HRESP,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HBURST,
    output logic [2:0]            HSIZE,
    output logic                  HWRITE,
    output logic [3:0]            HPROT,
    output logic [LEN_WIDTH-1:0]  beatCount,
    output logic                  done,
    output logic                  err
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    ahb_seq_state_e        state_q;
    ahb_transfer_e         htrans_q;
    ahb_burst_cmd_s        cmd_q;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic [LEN_WIDTH-1:0]  beat_count_q;
    logic [LEN_WIDTH-1:0]  beats_total_q;
    logic                  done_q;
    logic                  err_q;
    logic                  cmd_ready_q;

    // The address generator is shared: while idle it looks at the incoming
    // command (for the 1KB legality check), otherwise at the current beat.
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic [2:0]            gen_burst;
    logic [2:0]            gen_size;
    logic [ADDR_WIDTH-1:0] gen_next;
    logic [ADDR_WIDTH-1:0] gen_span;
    logic                  gen_kb_cross;

    always_comb begin
        if (state_q == ST_IDLE) begin
            gen_addr  = cmdAddr;
            gen_burst = cmdBurst;
            gen_size  = cmdSize;
        end else begin
            gen_addr  = haddr_q;
            gen_burst = cmd_q.burst;
            gen_size  = cmd_q.size;
        end
    end

    ahb_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr_i      (gen_addr),
        .burst_i     (gen_burst),
        .size_i      (gen_size),
        .next_addr_o (gen_next),
        .wrap_span_o (gen_span),
        .kb_cross_o  (gen_kb_cross)
    );

    // Command legality: size wider than the bus, misaligned start, or a
    // fixed-length INCR burst that would run past a 1KB page.
    logic [ADDR_WIDTH-1:0] size_mask;
    logic                  cmd_illegal;
    int                    incr_len;

    always_comb begin
        size_mask   = (ADDR_WIDTH'(1) << cmdSize) - ADDR_WIDTH'(1);
        cmd_illegal = (cmdSize > 3'(MAX_SIZE))
                   || ((cmdAddr & size_mask) != '0)
                   || (is_fixed_incr(ahb_burst_e'(cmdBurst))
                       && ((ADDR_WIDTH'(cmdAddr[9:0]) + gen_span) > ADDR_WIDTH'(KB_BOUNDARY)));
        incr_len    = (int'(cmdLen) > MAX_INCR_LEN) ? MAX_INCR_LEN : int'(cmdLen);
    end

    // An ERROR response can only belong to us once a beat has been accepted.
    logic                 data_error;
    logic [LEN_WIDTH-1:0] beat_count_inc;
    logic                 final_beat;

    always_comb begin
        data_error     = HRESP && !HREADY && (beat_count_q != '0);
        beat_count_inc = beat_count_q + LEN_WIDTH'(1);
        final_beat     = (beat_count_inc == beats_total_q);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q       <= ST_IDLE;
            htrans_q      <= HTRANS_IDLE;
            cmd_q         <= '0;
            haddr_q       <= '0;
            beat_count_q  <= '0;
            beats_total_q <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            cmd_ready_q   <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmdValid) begin
                        if (cmd_illegal) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state_q       <= ST_NSEQ;
                            htrans_q      <= HTRANS_NONSEQ;
                            haddr_q       <= cmdAddr;
                            cmd_q.burst   <= ahb_burst_e'(cmdBurst);
                            cmd_q.size    <= ahb_hsize_e'(cmdSize);
                            cmd_q.write   <= cmdWrite;
                            cmd_q.prot    <= cmdProt;
                            beat_count_q  <= '0;
                            beats_total_q <= LEN_WIDTH'(burst_beats(ahb_burst_e'(cmdBurst), incr_len));
                            cmd_ready_q   <= 1'b0;
                        end
                    end
                end
                ST_NSEQ, ST_SEQ: begin
                    if (data_error) begin
                        state_q  <= ST_ERR;
                        htrans_q <= HTRANS_IDLE;
                    end else if (HREADY) begin
                        beat_count_q <= beat_count_inc;
                        if (final_beat) begin
                            state_q  <= ST_LAST;
                            htrans_q <= HTRANS_IDLE;
                        end else begin
                            haddr_q <= gen_next;
                            // A beat opening a new 1KB page restarts as NONSEQ,
                            // and BUSY may not precede a NONSEQ.
                            if (gen_kb_cross) begin
                                state_q  <= ST_NSEQ;
                                htrans_q <= HTRANS_NONSEQ;
                            end else if (beatStall) begin
                                state_q  <= ST_BUSY;
                                htrans_q <= HTRANS_BUSY;
                            end else begin
                                state_q  <= ST_SEQ;
                                htrans_q <= HTRANS_SEQ;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (data_error) begin
                        state_q  <= ST_ERR;
                        htrans_q <= HTRANS_IDLE;
                    end else if (HREADY && !beatStall) begin
                        state_q  <= ST_SEQ;
                        htrans_q <= HTRANS_SEQ;
                    end
                end
                ST_LAST: begin
                    if (data_error) begin
                        state_q <= ST_ERR;
                    end else if (HREADY) begin
                        state_q     <= ST_IDLE;
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_ERR: begin
                    if (HREADY) begin
                        state_q     <= ST_IDLE;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    htrans_q    <= HTRANS_IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmdReady  = cmd_ready_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HBURST    = cmd_q.burst;
    assign HSIZE     = cmd_q.size;
    assign HWRITE    = cmd_q.write;
    assign HPROT     = cmd_q.prot;
    assign beatCount = beat_count_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ahb_burst_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ahb_burst_sequencer
// Directed bench for ahb_burst_sequencer. Inputs change 1ns after each rising
// edge; outputs are sampled at the same point, i.e. they show the result of
// the edge just passed. Expected values are hand-computed tables.
// ----------------------------------------------------------------------------
module tb_ahb_burst_sequencer;

    localparam int ADDR_WIDTH = 32;
    localparam int LEN_WIDTH  = $clog2(256 + 1);

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic                  HCLK;
    logic                  HRESET;
    logic                  cmdValid;
    logic                  cmdReady;
    logic [ADDR_WIDTH-1:0] cmdAddr;
    logic [2:0]            cmdBurst;
    logic [2:0]            cmdSize;
    logic                  cmdWrite;
    logic [3:0]            cmdProt;
    logic [LEN_WIDTH-1:0]  cmdLen;
    logic                  beatStall;
    logic                  HREADY;
    logic                  HRESP;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic [2:0]            HBURST;
    logic [2:0]            HSIZE;
    logic                  HWRITE;
    logic [3:0]            HPROT;
    logic [LEN_WIDTH-1:0]  beatCount;
    logic                  done;
    logic                  err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_addr  [16];
    logic [1:0]  exp_trans [16];

    ahb_burst_sequencer dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady),
        .cmdAddr   (cmdAddr),
        .cmdBurst  (cmdBurst),
        .cmdSize   (cmdSize),
        .cmdWrite  (cmdWrite),
        .cmdProt   (cmdProt),
        .cmdLen    (cmdLen),
        .beatStall (beatStall),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HPROT     (HPROT),
        .beatCount (beatCount),
        .done      (done),
        .err       (err)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [2:0] burst,
                         input logic [2:0] size, input logic [LEN_WIDTH-1:0] len);
        cmdAddr  = addr;
        cmdBurst = burst;
        cmdSize  = size;
        cmdLen   = len;
        cmdValid = 1'b1;
        step();
        cmdValid = 1'b0;
    endtask

    // Follows a burst with HREADY=1 throughout, starting on its NONSEQ beat.
    task automatic follow_burst(input string name, input int n);
        for (int b = 0; b < n; b++) begin
            check($sformatf("%s b%0d HTRANS", name, b), 64'(HTRANS), 64'(exp_trans[b]));
            check($sformatf("%s b%0d HADDR", name, b), 64'(HADDR), 64'(exp_addr[b]));
            check($sformatf("%s b%0d beatCount", name, b), 64'(beatCount), 64'(b));
            step();
        end
        check($sformatf("%s tail HTRANS", name), 64'(HTRANS), 64'(T_IDLE));
        check($sformatf("%s tail beatCount", name), 64'(beatCount), 64'(n));
        check($sformatf("%s tail done", name), 64'(done), 64'd0);
        step();
        check($sformatf("%s done", name), 64'(done), 64'd1);
        check($sformatf("%s err", name), 64'(err), 64'd0);
        check($sformatf("%s cmdReady", name), 64'(cmdReady), 64'd1);
        step();
        check($sformatf("%s done drop", name), 64'(done), 64'd0);
        $display("burst %s: %0d beats followed", name, n);
    endtask

    task automatic expect_illegal(input string name);
        check($sformatf("%s HTRANS", name), 64'(HTRANS), 64'(T_IDLE));
        check($sformatf("%s done", name), 64'(done), 64'd1);
        check($sformatf("%s err", name), 64'(err), 64'd1);
        check($sformatf("%s cmdReady", name), 64'(cmdReady), 64'd1);
        step();
        check($sformatf("%s done drop", name), 64'(done), 64'd0);
        check($sformatf("%s HTRANS after", name), 64'(HTRANS), 64'(T_IDLE));
        $display("command %s: rejected", name);
    endtask

    initial begin
        HRESET    = 1'b1;
        cmdValid  = 1'b0;
        cmdAddr   = '0;
        cmdBurst  = '0;
        cmdSize   = '0;
        cmdWrite  = 1'b1;
        cmdProt   = 4'b0011;
        cmdLen    = '0;
        beatStall = 1'b0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        step();
        step();
        HRESET = 1'b0;

        // Reset state
        check("rst HTRANS", 64'(HTRANS), 64'(T_IDLE));
        check("rst HADDR", 64'(HADDR), 64'd0);
        check("rst HBURST", 64'(HBURST), 64'd0);
        check("rst beatCount", 64'(beatCount), 64'd0);
        check("rst cmdReady", 64'(cmdReady), 64'd1);
        check("rst done", 64'(done), 64'd0);
        check("rst err", 64'(err), 64'd0);
        $display("reset: state checked");

        // INCR4 WORD at 0x100
        issue(32'h100, 3'd3, 3'd2, '0);
        check("incr4 cmdReady busy", 64'(cmdReady), 64'd0);
        check("incr4 HBURST", 64'(HBURST), 64'd3);
        check("incr4 HSIZE", 64'(HSIZE), 64'd2);
        check("incr4 HWRITE", 64'(HWRITE), 64'd1);
        check("incr4 HPROT", 64'(HPROT), 64'h3);
        exp_addr[0] = 32'h100; exp_trans[0] = T_NSEQ;
        exp_addr[1] = 32'h104; exp_trans[1] = T_SEQ;
        exp_addr[2] = 32'h108; exp_trans[2] = T_SEQ;
        exp_addr[3] = 32'h10C; exp_trans[3] = T_SEQ;
        follow_burst("incr4", 4);

        // WRAP8 WORD at 0x34 (window 0x20..0x3F)
        cmdWrite = 1'b0;
        cmdProt  = 4'b1010;
        issue(32'h34, 3'd4, 3'd2, '0);
        check("wrap8 HWRITE", 64'(HWRITE), 64'd0);
        check("wrap8 HPROT", 64'(HPROT), 64'hA);
        exp_addr[0] = 32'h34; exp_trans[0] = T_NSEQ;
        exp_addr[1] = 32'h38; exp_trans[1] = T_SEQ;
        exp_addr[2] = 32'h3C; exp_trans[2] = T_SEQ;
        exp_addr[3] = 32'h20; exp_trans[3] = T_SEQ;
        exp_addr[4] = 32'h24; exp_trans[4] = T_SEQ;
        exp_addr[5] = 32'h28; exp_trans[5] = T_SEQ;
        exp_addr[6] = 32'h2C; exp_trans[6] = T_SEQ;
        exp_addr[7] = 32'h30; exp_trans[7] = T_SEQ;
        follow_burst("wrap8", 8);

        // INCR len 4 HALFWORD at 0x3FC crosses a 1KB page
        issue(32'h3FC, 3'd1, 3'd1, 9'd4);
        exp_addr[0] = 32'h3FC; exp_trans[0] = T_NSEQ;
        exp_addr[1] = 32'h3FE; exp_trans[1] = T_SEQ;
        exp_addr[2] = 32'h400; exp_trans[2] = T_NSEQ;
        exp_addr[3] = 32'h402; exp_trans[3] = T_SEQ;
        follow_burst("incr1k", 4);

        // INCR with len 0 behaves as one beat; SINGLE is one beat
        issue(32'h80, 3'd1, 3'd2, 9'd0);
        exp_addr[0] = 32'h80; exp_trans[0] = T_NSEQ;
        follow_burst("incr0", 1);
        issue(32'h40, 3'd0, 3'd0, 9'd7);
        exp_addr[0] = 32'h40; exp_trans[0] = T_NSEQ;
        follow_burst("single", 1);

        // INCR4 ending exactly on a 1KB page boundary is legal
        issue(32'h3F0, 3'd3, 3'd2, '0);
        exp_addr[0] = 32'h3F0; exp_trans[0] = T_NSEQ;
        exp_addr[1] = 32'h3F4; exp_trans[1] = T_SEQ;
        exp_addr[2] = 32'h3F8; exp_trans[2] = T_SEQ;
        exp_addr[3] = 32'h3FC; exp_trans[3] = T_SEQ;
        follow_burst("incr4edge", 4);

        // INCR8 WORD at 0x200: two BUSY cycles after beat 2, wait on beat 5
        issue(32'h200, 3'd5, 3'd2, '0);
        check("stall b0 HTRANS", 64'(HTRANS), 64'(T_NSEQ));
        check("stall b0 HADDR", 64'(HADDR), 64'h200);
        step();
        check("stall b1 HTRANS", 64'(HTRANS), 64'(T_SEQ));
        check("stall b1 HADDR", 64'(HADDR), 64'h204);
        beatStall = 1'b1;
        step();
        check("stall busy1 HTRANS", 64'(HTRANS), 64'(T_BUSY));
        check("stall busy1 HADDR", 64'(HADDR), 64'h208);
        check("stall busy1 beatCount", 64'(beatCount), 64'd2);
        step();
        check("stall busy2 HTRANS", 64'(HTRANS), 64'(T_BUSY));
        check("stall busy2 HADDR", 64'(HADDR), 64'h208);
        beatStall = 1'b0;
        step();
        check("stall b2 HTRANS", 64'(HTRANS), 64'(T_SEQ));
        check("stall b2 HADDR", 64'(HADDR), 64'h208);
        check("stall b2 beatCount", 64'(beatCount), 64'd2);
        step();
        check("stall b3 HADDR", 64'(HADDR), 64'h20C);
        step();
        check("stall b4 HADDR", 64'(HADDR), 64'h210);
        check("stall b4 beatCount", 64'(beatCount), 64'd4);
        HREADY = 1'b0;
        step();
        check("stall wait1 HTRANS", 64'(HTRANS), 64'(T_SEQ));
        check("stall wait1 HADDR", 64'(HADDR), 64'h210);
        check("stall wait1 beatCount", 64'(beatCount), 64'd4);
        step();
        check("stall wait2 HADDR", 64'(HADDR), 64'h210);
        HREADY = 1'b1;
        step();
        check("stall b5 HADDR", 64'(HADDR), 64'h214);
        step();
        check("stall b6 HADDR", 64'(HADDR), 64'h218);
        step();
        check("stall b7 HADDR", 64'(HADDR), 64'h21C);
        check("stall b7 HTRANS", 64'(HTRANS), 64'(T_SEQ));
        step();
        check("stall tail HTRANS", 64'(HTRANS), 64'(T_IDLE));
        check("stall tail beatCount", 64'(beatCount), 64'd8);
        step();
        check("stall done", 64'(done), 64'd1);
        check("stall err", 64'(err), 64'd0);
        step();
        $display("burst incr8 stall: checked");

        // INCR16 WORD at 0x300, ERROR on beat 3 data phase
        issue(32'h300, 3'd7, 3'd2, '0);
        step();
        step();
        step();
        check("error b3 HADDR", 64'(HADDR), 64'h30C);
        check("error b3 beatCount", 64'(beatCount), 64'd3);
        HREADY = 1'b0;
        HRESP  = 1'b1;
        beatStall = 1'b1;
        step();
        check("error c1 HTRANS", 64'(HTRANS), 64'(T_IDLE));
        check("error c1 done", 64'(done), 64'd0);
        check("error c1 beatCount", 64'(beatCount), 64'd3);
        HREADY = 1'b1;
        step();
        check("error c2 done", 64'(done), 64'd1);
        check("error c2 err", 64'(err), 64'd1);
        check("error c2 cmdReady", 64'(cmdReady), 64'd1);
        check("error c2 beatCount", 64'(beatCount), 64'd3);
        HRESP = 1'b0;
        beatStall = 1'b0;
        step();
        check("error after done", 64'(done), 64'd0);
        check("error after HTRANS", 64'(HTRANS), 64'(T_IDLE));
        $display("burst incr16 error: checked");

        // Illegal commands
        issue(32'h0, 3'd3, 3'd3, '0);
        expect_illegal("dword");
        issue(32'h3F8, 3'd3, 3'd2, '0);
        expect_illegal("incr4x1k");
        issue(32'h102, 3'd0, 3'd2, '0);
        expect_illegal("misaligned");

        // Reset in the middle of a burst
        issue(32'h500, 3'd3, 3'd2, '0);
        step();
        step();
        check("midrst pre HADDR", 64'(HADDR), 64'h508);
        HRESET = 1'b1;
        step();
        check("midrst HTRANS", 64'(HTRANS), 64'(T_IDLE));
        check("midrst HADDR", 64'(HADDR), 64'd0);
        check("midrst HBURST", 64'(HBURST), 64'd0);
        check("midrst HSIZE", 64'(HSIZE), 64'd0);
        check("midrst HPROT", 64'(HPROT), 64'd0);
        check("midrst beatCount", 64'(beatCount), 64'd0);
        check("midrst cmdReady", 64'(cmdReady), 64'd1);
        HRESET = 1'b0;
        step();
        check("midrst no done", 64'(done), 64'd0);
        check("midrst no err", 64'(err), 64'd0);
        check("midrst idle", 64'(HTRANS), 64'(T_IDLE));
        $display("reset mid-burst: checked");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
